div_sequencer: RTL
==================

// Module: div_sequencer
// PURPOSE
// Multi-cycle iterative divider for RV32M DIV/DIVU/REM/REMU, replacing the combinational divide in the ALU.
// Sits beside the ALU in EX: the decoder routes OP_REG/funct7=0x01/funct3[2]=1 here; the pipeline stalls on !req_ready.
// Radix-2 restoring algorithm, one quotient bit per cycle, with valid/ready request and response handshakes.
// PARAMETERS
// DATA_W   32   operand/result width; only 32 is verified
// CNT_W    $clog2(DATA_W)   iteration counter width (derived, do not override)
// PORTS
// clk           in   1        system clock, all state on rising edge
// rst           in   1        asynchronous, active-high reset
// req_valid     in   1        request present
// req_ready     out  1        block can accept; 1 only in IDLE and only while flush=0
// req_funct3    in   3        4=DIV 5=DIVU 6=REM 7=REMU
// req_dividend  in   DATA_W   rs1 value
// req_divisor   in   DATA_W   rs2 value
// flush         in   1        synchronous abort (pipeline redirect)
// resp_valid    out  1        result available
// resp_ready    in   1        consumer takes result
// resp_result   out  DATA_W   quotient or remainder
// busy          out  1        state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, busy=0, counter=0.
// - FSM: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
// - IDLE: on req_valid&req_ready, latch funct3, |dividend|, |divisor| (sign-magnitude for DIV/REM), result signs; clear remainder, count=0 -> CALC.
// - CALC: per cycle shift {rem,quo} left 1, trial-subtract divisor, keep if non-negative, set quotient bit; count++; after count==DATA_W-1 -> FIXUP.
// - FIXUP: negate quotient if signs differ (DIV); negate remainder if dividend negative (REM); select by funct3[1]; load resp_result -> DONE.
// - DONE: resp_valid=1, resp_result stable; on resp_ready -> IDLE. Holds indefinitely while resp_ready=0.
// - Latency: accept edge N -> resp_valid high after edge N+DATA_W+1 (33 cycles for 32-bit); throughput one op per 34+ cycles.
// - No back-to-back accept in the DONE->IDLE transition cycle; req_ready rises the cycle after the response handshake.
// - Divide-by-zero: quotient=all ones, remainder=dividend (signed and unsigned).
// - Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0.
// - Both corner results must come out of the normal datapath or a FIXUP override; never from undefined hardware behaviour.
// - funct3[2]=0 (not a divide): protocol violation; block still completes and returns 0.
// - flush: any state -> IDLE on the next edge, resp_valid drops, result discarded; flush=1 forces req_ready=0 (flush beats a same-cycle request).
// - rst asserted mid-operation: immediate return to reset values, no response issued.
// - Width rule: remainder register is DATA_W+1 bits to hold the trial-subtract borrow; all negation is two's complement, modulo 2^DATA_W.
// CONFIGURATION
// - DIV_EARLY_OUT_EN defined: divisor==0 or signed overflow detected in IDLE goes IDLE -> DONE directly with the spec result; resp_valid one cycle after accept.
// - DIV_EARLY_OUT_EN undefined: these cases take the full CALC+FIXUP path (33 cycles); results are bit-identical either way.
// STRUCTURE
// - Package alu_pkg: opcode localparams (OP_REG etc.), FUNCT7_MULDIV=7'h01, FUNCT3_DIV/DIVU/REM/REMU, div_state_t enum {IDLE,CALC,FIXUP,DONE}.
// - One sub-module: div_step (combinational single restoring iteration: rem_in, quo_in, divisor -> rem_out, quo_out).
// - FSM, counter, operand/sign registers and FIXUP logic stay in div_sequencer.
// TESTING
// - DIVU 100/7 -> 14 at exactly 33 cycles after accept; REMU 100/7 -> 2.
// - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
// - DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; latency 1 cycle with DIV_EARLY_OUT_EN, 33 without.
// - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
// - Hold resp_ready=0 for 5 cycles in DONE -> resp_result stable, req_ready=0; release -> next request accepted one cycle later.
// - Flush at CALC count=10 -> IDLE next edge, no resp_valid; async rst mid-CALC -> reset values; following DIVU 9/3 -> 3.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Purpose: shared decode constants for the EX stage and the state type used by
// the iterative divider (div_sequencer).
// Contents:
//   OP_*            major opcodes seen by the EX-stage decoder
//   FUNCT7_MULDIV   funct7 value that selects the M extension
//   FUNCT3_DIV..    funct3 encodings of the four divide operations
//   div_state_t     divider FSM states
//   isDivideOp      funct3[2] marks a real divide/remainder request
//   isSignedOp      funct3[0]=0 marks the signed variants (DIV/REM)
package alu_pkg;

  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  localparam logic [2:0] FUNCT3_DIV  = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU = 3'd5;
  localparam logic [2:0] FUNCT3_REM  = 3'd6;
  localparam logic [2:0] FUNCT3_REMU = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } div_state_t;

  function automatic logic isDivideOp(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic isSignedOp(input logic [2:0] funct3);
    return ~funct3[0];
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step
// Purpose: one combinational iteration of radix-2 restoring division on
// magnitudes. Shifts {rem,quo} left by one, trial-subtracts the divisor from
// the partial remainder and keeps the difference when it does not borrow.
// Ports:
//   rem_in   [DATA_W:0]    partial remainder before this iteration
//   quo_in   [DATA_W-1:0]  dividend bits still to shift in / quotient so far
//   divisor  [DATA_W-1:0]  divisor magnitude
//   rem_out  [DATA_W:0]    partial remainder after this iteration
//   quo_out  [DATA_W-1:0]  quo_in shifted left with the new quotient bit in bit 0
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0]   w_shifted;
  logic [DATA_W+1:0] w_diff;
  logic              w_keep;

  assign w_shifted = {rem_in[DATA_W-1:0], quo_in[DATA_W-1]};
  assign w_diff    = {1'b0, w_shifted} - {2'b00, divisor};

  // The partial remainder is always below the divisor, so rem_in[DATA_W] stays
  // clear in practice; if it were ever set the shifted value would exceed any
  // divisor and the subtraction must be kept.
  assign w_keep = rem_in[DATA_W] | ~w_diff[DATA_W+1];

  assign rem_out = w_keep ? w_diff[DATA_W:0] : w_shifted;
  assign quo_out = {quo_in[DATA_W-2:0], w_keep};

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer
// Purpose: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are converted to magnitudes on accept, DATA_W iterations of
// div_step produce the unsigned quotient/remainder, and a FIXUP cycle applies
// signs and the divide-by-zero quotient before the result is presented.
// Optional feature: define DIV_EARLY_OUT_EN to send divide-by-zero and signed
// overflow straight from IDLE to DONE; results are identical either way.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready request handshake (ready only in IDLE while flush=0)
//   req_funct3      4=DIV 5=DIVU 6=REM 7=REMU
//   req_dividend    rs1 value
//   req_divisor     rs2 value
//   flush           synchronous abort back to IDLE, result discarded
//   resp_valid/ready response handshake
//   resp_result     quotient or remainder, stable while resp_valid=1
//   busy            high whenever the FSM is not in IDLE
module div_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_dividend,
  input  logic [DATA_W-1:0] req_divisor,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              busy
);

  import alu_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);

  div_state_t        r_state;
  div_state_t        w_nextState;
  logic [CNT_W-1:0]  r_count;
  logic              r_isDiv;
  logic              r_wantRem;
  logic              r_negQuo;
  logic              r_negRem;
  logic              r_divZero;
  logic [DATA_W:0]   r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_divisor;
  logic [DATA_W-1:0] r_result;

  logic              w_accept;
  logic              w_lastIter;
  logic              w_signedOp;
  logic              w_dividendNeg;
  logic              w_divisorNeg;
  logic [DATA_W-1:0] w_absDividend;
  logic [DATA_W-1:0] w_absDivisor;
  logic [DATA_W:0]   w_stepRem;
  logic [DATA_W-1:0] w_stepQuo;
  logic [DATA_W-1:0] w_fixQuo;
  logic [DATA_W-1:0] w_fixRem;
  logic [DATA_W-1:0] w_fixResult;
  logic              w_earlyOut;

  assign w_accept   = (r_state == IDLE) && req_valid && !flush;
  assign w_lastIter = (r_count == CNT_W'(DATA_W - 1));

  // Signed ops work on magnitudes; the most negative value maps onto itself,
  // which is still the correct unsigned magnitude modulo 2^DATA_W.
  assign w_signedOp    = isSignedOp(req_funct3);
  assign w_dividendNeg = w_signedOp && req_dividend[DATA_W-1];
  assign w_divisorNeg  = w_signedOp && req_divisor[DATA_W-1];
  assign w_absDividend = w_dividendNeg ? -req_dividend : req_dividend;
  assign w_absDivisor  = w_divisorNeg  ? -req_divisor  : req_divisor;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_divisor),
    .rem_out (w_stepRem),
    .quo_out (w_stepQuo)
  );

  // A zero divisor leaves the quotient all ones and the remainder equal to the
  // dividend magnitude; only the signed quotient needs the override, because
  // negating all ones for a negative dividend would give 1.
  assign w_fixQuo    = r_divZero ? '1 : (r_negQuo ? -r_quo : r_quo);
  assign w_fixRem    = r_negRem ? -r_rem[DATA_W-1:0] : r_rem[DATA_W-1:0];
  assign w_fixResult = !r_isDiv ? '0 : (r_wantRem ? w_fixRem : w_fixQuo);

`ifdef DIV_EARLY_OUT_EN
  logic              w_overflow;
  logic              w_divByZero;
  logic [DATA_W-1:0] w_earlyResult;

  assign w_divByZero = (req_divisor == '0);
  assign w_overflow  = w_signedOp && (req_dividend == {1'b1, {(DATA_W-1){1'b0}}})
                       && (req_divisor == '1);
  assign w_earlyOut  = isDivideOp(req_funct3) && (w_divByZero || w_overflow);

  // Overflow quotient is the dividend itself (the most negative value).
  always_comb begin
    w_earlyResult = '0;
    if (w_divByZero) begin
      w_earlyResult = req_funct3[1] ? req_dividend : '1;
    end else begin
      w_earlyResult = req_funct3[1] ? '0 : req_dividend;
    end
  end
`else
  assign w_earlyOut = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and handshake outputs; flush overrides every transition.
  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = !flush;
        if (w_accept) begin
          w_nextState = w_earlyOut ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_lastIter) begin
          w_nextState = FIXUP;
        end
      end
      FIXUP: begin
        w_nextState = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_nextState = IDLE;
        end
      end
    endcase
    if (flush) begin
      w_nextState = IDLE;
      resp_valid  = 1'b0;
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_wantRem <= 1'b0;
      r_negQuo  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_isDiv   <= isDivideOp(req_funct3);
            r_wantRem <= req_funct3[1];
            r_negQuo  <= w_dividendNeg ^ w_divisorNeg;
            r_negRem  <= w_dividendNeg;
            r_divZero <= (req_divisor == '0);
            r_rem     <= '0;
            r_quo     <= w_absDividend;
            r_divisor <= w_absDivisor;
            r_count   <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (w_earlyOut) begin
              r_result <= w_earlyResult;
            end
`endif
          end
        end
        CALC: begin
          r_rem   <= w_stepRem;
          r_quo   <= w_stepQuo;
          r_count <= r_count + 1'b1;
        end
        FIXUP: begin
          r_result <= w_fixResult;
        end
        DONE: begin
        end
      endcase
    end
  end

  assign resp_result = r_result;

endmodule
